irs3_serial_dac_rx: RTL and testbench

Synthesizable receiver/emulator for the IRS3 serial DAC load interface: samples SCLK/SIN/PCLK/REGCLR as driven by the DAC loader, rebuilds the 145-bit frame, and latches decoded DAC fields on PCLK.
- Used on ATRI boards without a populated IRS3 (loopback/bring-up) and in benches as a checkable model of the chip end.
- Drives SHOUT exactly as the chip's shift chain does.

---
 rtl/irs3_serial_dac_rx.sv | 116 +++++++++++
 tb/tb_irs3_serial_dac_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/irs3_serial_dac_rx.sv
// Chip-side model of the IRS3 serial DAC load port: rebuilds the 145-bit shift frame
// from SCLK/SIN and latches decoded DAC fields on PCLK, with length/protocol checking.
`timescale 1ns/1ps
module irs3_serial_dac_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int EXPECT_BITS = 145
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irs_sclk_i,
  input  logic        irs_sin_i,
  input  logic        irs_pclk_i,
  input  logic        irs_regclr_i,
  output logic        irs_shout_o,
  output logic [11:0] sbbias_o,
  output logic [11:0] trgthref_o,
  output logic [95:0] trig_o,
  output logic [11:0] tbbias_o,
  output logic [11:0] trgbias_o,
  output logic        sgn_o,
  output logic        latch_valid_o,
  output logic [7:0]  frame_bits_o,
  output logic        len_err_o,
  input  logic        err_clr_i
);

  localparam int         FRAME_W    = 145;
  localparam logic [7:0] EXPECT_CNT = 8'(EXPECT_BITS);
  localparam logic [7:0] CNT_MAX    = 8'hFF;

  // bit order in the synchronizer vector: {regclr, pclk, sin, sclk}
  logic [3:0] raw_in;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_out;
  logic [2:0] hist_q;
  logic [2:0] edge_in;

  logic sclk_ev;
  logic pclk_ev;
  logic regclr_ev;
  logic sin_sync;
  logic err_set;

  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] hold_q;
  logic [7:0]         bit_cnt_q;
  logic [7:0]         frame_bits_q;
  logic               valid_q;
  logic               err_q;

  assign raw_in = {irs_regclr_i, irs_pclk_i, irs_sin_i, irs_sclk_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= {sync_out[3], sync_out[2], sync_out[0]};
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign sin_sync  = sync_out[1];
  assign edge_in   = {sync_out[3], sync_out[2], sync_out[0]} & ~hist_q;
  assign sclk_ev   = edge_in[0];
  assign pclk_ev   = edge_in[1];
  assign regclr_ev = edge_in[2];

  // A PCLK that coincides with an SCLK edge is a protocol violation even when the count is right.
  assign err_set = pclk_ev & ~regclr_ev & ((bit_cnt_q != EXPECT_CNT) | sclk_ev);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q      <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      frame_bits_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (regclr_ev) begin
        shift_q   <= '0;
        hold_q    <= '0;
        bit_cnt_q <= '0;
      end else if (pclk_ev) begin
        if (bit_cnt_q == EXPECT_CNT) begin
          hold_q  <= shift_q;
          valid_q <= 1'b1;
        end
        frame_bits_q <= bit_cnt_q;
        bit_cnt_q    <= '0;
      end else if (sclk_ev) begin
        shift_q <= {shift_q[FRAME_W-2:0], sin_sync};
        if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 8'd1;
      end

      if (err_set) err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign irs_shout_o   = shift_q[FRAME_W-1];
  assign sbbias_o      = hold_q[144:133];
  assign trgthref_o    = hold_q[132:121];
  assign trig_o        = hold_q[120:25];
  assign tbbias_o      = hold_q[24:13];
  assign trgbias_o     = hold_q[12:1];
  assign sgn_o         = hold_q[0];
  assign latch_valid_o = valid_q;
  assign frame_bits_o  = frame_bits_q;
  assign len_err_o     = err_q;

endmodule

// File: tb/tb_irs3_serial_dac_rx.sv
// Directed bench for irs3_serial_dac_rx: drives the loader protocol slowly enough for the
// synchronizers and compares latched fields and status against hand-built frames.
`timescale 1ns/1ps
module tb_irs3_serial_dac_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0, sin = 1'b0, pclk = 1'b0, regclr = 1'b0, err_clr = 1'b0;
  logic        shout;
  logic [11:0] sbbias, trgthref, tbbias, trgbias;
  logic [95:0] trig;
  logic        sgn, latch_valid, len_err;
  logic [7:0]  frame_bits;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int valid_long = 0;
  logic valid_prev = 1'b0;
  logic b3 [300];

  localparam logic [144:0] F1 = {12'h123, 12'h7FF, 12'h800, 84'h0, 12'h7FF, 12'h000, 1'b0};
  localparam logic [144:0] F5 = {12'h5A5, 12'h0F0, 96'h0123456789ABCDEF01234567,
                                 12'h3C3, 12'h81F, 1'b1};
  localparam logic [144:0] F6 = {12'hFFF, 12'h001, 96'hFEDCBA987654321000000000,
                                 12'h456, 12'h789, 1'b0};

  irs3_serial_dac_rx #(.SYNC_STAGES(2), .EXPECT_BITS(145)) dut (
    .clk_i(clk), .rst_i(rst),
    .irs_sclk_i(sclk), .irs_sin_i(sin), .irs_pclk_i(pclk), .irs_regclr_i(regclr),
    .irs_shout_o(shout),
    .sbbias_o(sbbias), .trgthref_o(trgthref), .trig_o(trig),
    .tbbias_o(tbbias), .trgbias_o(trgbias), .sgn_o(sgn),
    .latch_valid_o(latch_valid), .frame_bits_o(frame_bits), .len_err_o(len_err),
    .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (latch_valid === 1'b1) begin
      valid_cnt++;
      if (valid_prev) valid_long++;
    end
    valid_prev = (latch_valid === 1'b1);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    cyc(4);
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [144:0] f);
    for (int i = 144; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic strobe_pclk();
    cyc(4);
    pclk = 1'b1;
    cyc(4);
    pclk = 1'b0;
    cyc(4);
  endtask

  task automatic strobe_regclr();
    cyc(4);
    regclr = 1'b1;
    cyc(4);
    regclr = 1'b0;
    cyc(4);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  function automatic logic [144:0] fields();
    return {sbbias, trgthref, trig, tbbias, trgbias, sgn};
  endfunction

  initial begin
    cyc(3);
    chk("rst_fields", fields(), 145'h0);
    chk("rst_status", {latch_valid, len_err, frame_bits, shout}, 11'h0);
    @(negedge clk); rst = 1'b0;
    cyc(4);

    // 1: clean frame
    send_frame(F1);
    strobe_pclk();
    chk("t1_fields", fields(), F1);
    chk("t1_sbbias", sbbias, 12'h123);
    chk("t1_trig1", trig[95:84], 12'h800);
    chk("t1_valid_cnt", valid_cnt, 1);
    chk("t1_valid_width", valid_long, 0);
    chk("t1_frame_bits", frame_bits, 8'd145);
    chk("t1_len_err", len_err, 1'b0);

    // 2: short frame
    for (int i = 0; i < 144; i++) send_bit(1'b1);
    strobe_pclk();
    chk("t2_fields_kept", fields(), F1);
    chk("t2_len_err", len_err, 1'b1);
    chk("t2_frame_bits", frame_bits, 8'd144);
    chk("t2_no_latch", valid_cnt, 1);
    clear_err();
    chk("t2_err_clr", len_err, 1'b0);

    // 3: long frame, shout shows the bit from 145 shifts earlier
    for (int i = 0; i < 300; i++) begin
      b3[i] = ((i * 5) % 7) < 3;
      send_bit(b3[i]);
      if (i == 144 || i == 200 || i == 231 || i == 299)
        chk($sformatf("t3_shout_%0d", i), shout, b3[i-144]);
    end
    strobe_pclk();
    chk("t3_frame_bits", frame_bits, 8'd255);
    chk("t3_len_err", len_err, 1'b1);
    chk("t3_no_latch", valid_cnt, 1);
    chk("t3_fields_kept", fields(), F1);
    clear_err();

    // 4: regclr mid-frame then alternating frame
    for (int i = 0; i < 60; i++) send_bit(1'b1);
    strobe_regclr();
    chk("t4_cleared", fields(), 145'h0);
    chk("t4_no_valid", valid_cnt, 1);
    for (int i = 0; i < 145; i++) send_bit((i % 2) == 0);
    strobe_pclk();
    chk("t4_sbbias", sbbias, 12'hAAA);
    chk("t4_sgn", sgn, 1'b1);
    chk("t4_trgbias", trgbias, 12'hAAA);
    chk("t4_frame_bits", frame_bits, 8'd145);
    chk("t4_len_err", len_err, 1'b0);
    chk("t4_valid_cnt", valid_cnt, 2);

    // 5: PCLK together with an SCLK edge
    send_frame(F5);
    sin = 1'b1;
    cyc(4);
    sclk = 1'b1;
    pclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
    pclk = 1'b0;
    cyc(4);
    chk("t5_fields_preshift", fields(), F5);
    chk("t5_len_err", len_err, 1'b1);
    chk("t5_frame_bits", frame_bits, 8'd145);
    chk("t5_valid_cnt", valid_cnt, 3);
    strobe_pclk();
    chk("t5_cnt_zeroed", frame_bits, 8'd0);
    chk("t5_empty_fields_kept", fields(), F5);

    // 6: async reset mid-frame
    for (int i = 0; i < 70; i++) send_bit(F6[144-i]);
    sin = 1'b1;
    cyc(2);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_fields", fields(), 145'h0);
    chk("t6_rst_status", {latch_valid, len_err, frame_bits, shout}, 11'h0);
    cyc(3);
    rst = 1'b0;
    cyc(4);
    send_frame(F6);
    strobe_pclk();
    chk("t6_fields", fields(), F6);
    chk("t6_frame_bits", frame_bits, 8'd145);
    chk("t6_len_err", len_err, 1'b0);
    chk("t6_valid_cnt", valid_cnt, 4);
    chk("valid_width_all", valid_long, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
